dmem_sram_ctrl: RTL and testbench
=================================

DMEM_SRAM_CTRL -- requirements
Module: dmem_sram_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words; power of 2, range 4..65536.
REQ-003 SHALL have port clk  input  1  clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-010 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-014 SHALL have port rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  access fault.
REQ-016 SHALL have port init_done  output  1  high once the post-reset clear finishes.

Function
REQ-017 SHALL implement a three-state FSM: CLEAR, IDLE, RESP.
REQ-018 In CLEAR: one word per cycle written to 0, index counting 0..DEPTH_WORDS-1; go to IDLE after the last word; req_ready=0.
REQ-019 init_done SHALL rise on the cycle IDLE is first entered and stay 1 until reset.
REQ-020 req_ready SHALL be 1 in IDLE, and in RESP only when rsp_ready=1 (back-to-back, one request per cycle).
REQ-021 Acceptance (req_valid & req_ready at a rising edge) SHALL load the response register and enter or stay in RESP; rsp_valid is 1 the following cycle (latency 1).
REQ-022 RESP with rsp_ready=1 and no new acceptance SHALL return to IDLE; rsp_valid drops next cycle.
REQ-023 While rsp_valid=1 and rsp_ready=0, rsp_rdata and rsp_err SHALL hold stable.
REQ-024 Error conditions: address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS); size 3; half with addr[0]=1; word with addr[1:0]!=0.
REQ-025 On error: no array write, rsp_err=1, rsp_rdata=0.
REQ-026 Word index = (req_addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits.
REQ-027 Store SHALL write only the addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2..+1; word: all), with data shifted into the lane, committed at the acceptance edge.
REQ-028 Store response: rsp_err=0, rsp_rdata=0.
REQ-029 Load SHALL read the array at the acceptance edge, extract the addressed lane(s) and extend per req_unsigned; word loads ignore req_unsigned.
REQ-030 A load accepted the cycle after a store to the same word SHALL return the updated data.
REQ-031 The storage array SHALL be byte-lane writable with no read-modify-write cycle.

Reset
REQ-032 On rst: state=CLEAR, clear index=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, req_ready=0.
REQ-033 Reset during CLEAR or RESP SHALL abort the activity, drop any pending response and restart the clear from word 0.
REQ-034 Array contents need not be reset asynchronously; CLEAR provides the zero state.

Verification
REQ-035 Reset release -> req_ready=0 for exactly DEPTH_WORDS cycles (256 at default); then init_done=1, req_ready=1; a word load at 0x8000_0000 returns 0.
REQ-036 Store word 0xDEADBEEF @0x8000_0010, then store byte 0x55 @0x8000_0011 -> load word @0x8000_0010 returns 0xDEAD55EF, err=0.
REQ-037 Load byte signed @0x8000_0013 after REQ-036 -> 0xFFFFFFDE; unsigned -> 0x000000DE; half signed @0x8000_0012 -> 0xFFFFDEAD.
REQ-038 Word load @0x8000_0402, half @0x8000_0001, size 3, load @0x7FFF_FFFC, store @0x8000_0400 -> each rsp_err=1, rsp_rdata=0, array unchanged.
REQ-039 Back-to-back: req_valid and rsp_ready held 1 for 4 requests -> 4 consecutive rsp_valid cycles, in order; rsp_ready=0 for 3 cycles -> req_ready=0, response held stable.
REQ-040 Reset asserted with rsp_valid=1 -> rsp_valid=0 immediately, CLEAR restarts, previously stored 0xDEAD55EF reads 0 afterward.

Source files
------------

// File: rtl/dmem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dmem_sram_ctrl
// Purpose : Data-memory controller around a byte-lane writable word array.
//           After reset the array is cleared one word per cycle; afterwards
//           byte/half/word loads and stores are served with a one-cycle
//           response latency and valid/ready handshakes on both sides.
// Ports   : clk, rst            - clock (rising edge), async active-high reset
//           req_valid/req_ready - request handshake
//           req_we, req_addr, req_size, req_unsigned, req_wdata - request
//           rsp_valid/rsp_ready - response handshake
//           rsp_rdata, rsp_err  - extended load data / access fault
//           init_done           - high once the post-reset clear has finished
// Rev     : 1.0 - initial release
// ============================================================================
module dmem_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic               init_done_q, init_done_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  // Storage: one packed word of four byte lanes per entry so a store can
  // update only its lanes in a single write.
  logic [3:0][7:0]    mem [DEPTH_WORDS];

  // --------------------------------------------------------------------------
  // Address decode and access checks
  // --------------------------------------------------------------------------
  logic [31:0]        addr_off;
  logic               in_range;
  logic               size_err;
  logic               align_err;
  logic               acc_err;
  logic [IDX_W-1:0]   word_idx;

  // A 32-bit subtraction wraps addresses below BASE_ADDR to huge offsets, so
  // a single "no bits above the array span" test covers both range ends.
  assign addr_off  = req_addr - BASE_ADDR;
  assign in_range  = (addr_off >> (IDX_W + 2)) == 32'd0;
  assign word_idx  = addr_off[IDX_W+1:2];
  assign size_err  = (req_size == 2'd3);
  assign align_err = ((req_size == 2'd1) && req_addr[0]) ||
                     ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign acc_err   = ~in_range | size_err | align_err;

  // --------------------------------------------------------------------------
  // Load extraction and store lane steering
  // --------------------------------------------------------------------------
  logic [31:0]        rd_word;
  logic [31:0]        rd_shift;
  logic [4:0]         rd_sh;
  logic [31:0]        load_ext;
  logic [3:0]         lane_be;
  logic [31:0]        lane_wdata;

  assign rd_word  = mem[word_idx];
  assign rd_sh    = {req_addr[1:0], 3'b000};
  assign rd_shift = rd_word >> rd_sh;

  always_comb begin
    load_ext   = rd_word;
    lane_be    = 4'b0000;
    lane_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        load_ext   = req_unsigned ? {24'd0, rd_shift[7:0]}
                                  : {{24{rd_shift[7]}}, rd_shift[7:0]};
        lane_be    = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        load_ext   = req_unsigned ? {16'd0, rd_shift[15:0]}
                                  : {{16{rd_shift[15]}}, rd_shift[15:0]};
        lane_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        load_ext   = rd_word;
        lane_be    = 4'b1111;
        lane_wdata = req_wdata;
      end
      default: begin
        load_ext   = 32'd0;
        lane_be    = 4'b0000;
        lane_wdata = req_wdata;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM: next state and outputs
  // --------------------------------------------------------------------------
  logic               req_ready_w;
  logic               accept;
  logic               clr_we;
  logic               st_we;

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    init_done_d = init_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready_w = 1'b0;
    clr_we      = 1'b0;
    st_we       = 1'b0;
    accept      = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        req_ready_w = 1'b1;
      end
      ST_RESP: begin
        // A new request may only enter when the current response leaves.
        req_ready_w = rsp_ready;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    accept = req_valid & req_ready_w;
    if (accept) begin
      state_d     = ST_RESP;
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_err | req_we) ? 32'd0 : load_ext;
      st_we       = req_we & ~acc_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= '0;
      init_done_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      init_done_q <= init_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array writes: the clear sequence owns the array while in CLEAR; the
  // contents themselves are not reset, the clear sweep zeroes them.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx_q] <= '0;
    end else if (st_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) begin
          mem[word_idx][i] <= lane_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_w;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign init_done = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_sram_ctrl
// Purpose : Self-checking bench for dmem_sram_ctrl. Requests are issued by a
//           driver that pushes the expected response into a queue; a monitor
//           pops and compares whenever a response is handed over. Expected
//           values come from a byte-addressed memory model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_dmem_sram_ctrl;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 256;
  localparam int          BYTES = DEPTH * 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  dmem_sram_ctrl #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_done    (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] exp_q[$];          // {rdata, err}
  logic [7:0]  mdl[BYTES];        // byte-addressed reference memory
  bit          rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < BYTES; i++) mdl[i] = 8'h00;
  endtask

  // Little-endian byte memory: an access touches 1, 2 or 4 consecutive bytes.
  task automatic model_access(input logic we, input logic [31:0] a, input logic [1:0] sz,
                              input logic un, input logic [31:0] wd, output logic [32:0] r);
    longint off;
    int     nb;
    int     o;
    logic [31:0] v;
    bit     err;
    nb  = 1 << sz;
    off = longint'(a) - longint'(BASE);
    err = (sz == 2'd3) || (off < 0) || (off >= BYTES) || ((a % nb) != 0);
    if (err) begin
      r = {32'd0, 1'b1};
    end else begin
      o = int'(off);
      if (we) begin
        for (int i = 0; i < nb; i++) mdl[o + i] = wd[8*i +: 8];
        r = {32'd0, 1'b0};
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[o + i];
        if (!un && nb < 4 && v[8*nb-1]) begin
          for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
        end
        r = {v, 1'b0};
      end
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic un, input logic [31:0] wd,
                       input bit use_exp, input logic [31:0] erd, input logic eerr);
    logic [32:0] r;
    int          w;
    bit          acc;
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = a;
    req_size     = sz;
    req_unsigned = un;
    req_wdata    = wd;
    w   = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1;
      end else begin
        w++;
        if (w > 200) begin
          n_tests++;
          n_fail++;
          $display("FAIL issue_timeout: req_ready low %0d cycles, required 1", w);
          break;
        end
      end
    end
    if (acc) begin
      model_access(we, a, sz, un, wd, r);
      if (use_exp) r = {erd, eerr};
      exp_q.push_back(r);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      if (cnt == 0) chk("init_done_during_clear", 32'(init_done), 32'd0);
      cnt++;
      if (cnt > DEPTH + 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL clear_timeout: req_ready low %0d cycles, required %0d", cnt, DEPTH);
        break;
      end
    end
    chk("clear_cycles", 32'(cnt), 32'(DEPTH));
    chk("init_done", 32'(init_done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Random response back-pressure
  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard
  int          cyc = 0;
  int          last_pop = -10;
  int          run = 0;
  int          max_run = 0;
  bit          held = 1'b0;
  logic [31:0] hrd;
  logic        herr;

  always @(negedge clk) begin
    logic [32:0] e;
    cyc++;
    if (rst || !rsp_valid) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_rdata", rsp_rdata, hrd);
        chk("hold_err", 32'(rsp_err), 32'(herr));
      end
      if (rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rdata %08h err %0d, required no response", rsp_rdata, rsp_err);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e[32:1]);
          chk("rsp_err", 32'(rsp_err), 32'(e[0]));
        end
        run      = (last_pop == cyc - 1) ? run + 1 : 1;
        last_pop = cyc;
        if (run > max_run) max_run = run;
        held = 1'b0;
      end else begin
        held = 1'b1;
        hrd  = rsp_rdata;
        herr = rsp_err;
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          d;

    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 32'd0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'd0;
    rsp_ready    = 1'b1;
    model_clear();

    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_init();

    // Cleared memory, stores with lane merge, extension
    issue(0, BASE,               2'd2, 0, 32'd0,         1, 32'h0000_0000, 0);
    issue(1, 32'h8000_0010,      2'd2, 0, 32'hDEADBEEF,  1, 32'h0000_0000, 0);
    issue(1, 32'h8000_0011,      2'd0, 0, 32'h0000_0055, 1, 32'h0000_0000, 0);
    issue(0, 32'h8000_0010,      2'd2, 0, 32'd0,         1, 32'hDEAD55EF,  0);
    issue(0, 32'h8000_0013,      2'd0, 0, 32'd0,         1, 32'hFFFFFFDE,  0);
    issue(0, 32'h8000_0013,      2'd0, 1, 32'd0,         1, 32'h000000DE,  0);
    issue(0, 32'h8000_0012,      2'd1, 0, 32'd0,         1, 32'hFFFFDEAD,  0);

    // Faults
    issue(0, 32'h8000_0402,      2'd2, 0, 32'd0,         1, 32'h0, 1);
    issue(0, 32'h8000_0001,      2'd1, 0, 32'd0,         1, 32'h0, 1);
    issue(0, 32'h8000_0010,      2'd3, 0, 32'd0,         1, 32'h0, 1);
    issue(0, 32'h7FFF_FFFC,      2'd2, 0, 32'd0,         1, 32'h0, 1);
    issue(1, 32'h8000_0400,      2'd2, 0, 32'h12345678,  1, 32'h0, 1);
    issue(1, 32'h8000_0013,      2'd1, 0, 32'hFFFF,      1, 32'h0, 1);
    issue(0, BASE,               2'd2, 0, 32'd0,         1, 32'h0000_0000, 0);
    issue(0, 32'h8000_0010,      2'd2, 0, 32'd0,         1, 32'hDEAD55EF,  0);

    // Back-to-back
    idle(3);
    last_pop = -10;
    run      = 0;
    max_run  = 0;
    issue(0, 32'h8000_0010,      2'd2, 0, 32'd0,         1, 32'hDEAD55EF,  0);
    issue(0, 32'h8000_0013,      2'd0, 1, 32'd0,         1, 32'h000000DE,  0);
    issue(0, 32'h8000_0012,      2'd1, 1, 32'd0,         1, 32'h0000DEAD,  0);
    issue(0, 32'h8000_0010,      2'd0, 0, 32'd0,         1, 32'hFFFFFFEF,  0);
    idle(3);
    chk("b2b_consecutive", 32'(max_run), 32'd4);

    // Stall
    issue(0, 32'h8000_0011,      2'd0, 1, 32'd0,         1, 32'h00000055,  0);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    idle(2);

    // Randomized traffic with random back-pressure
    rdy_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      sz = 2'($urandom_range(0, 3));
      d  = $urandom_range(0, 15);
      if (d == 0)      a = BASE - 32'($urandom_range(1, 16));
      else if (d == 1) a = BASE + 32'(BYTES) + 32'($urandom_range(0, 16));
      else if (d < 9)  a = BASE + 32'($urandom_range(0, 63));
      else             a = BASE + 32'($urandom_range(0, BYTES - 1));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      issue(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom(), 0, 32'd0, 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rdy_rand = 1'b0;
    idle(1);
    rsp_ready = 1'b1;
    idle(4);

    // Reset with a response pending
    issue(1, 32'h8000_0010,      2'd2, 0, 32'hDEAD55EF,  1, 32'h0000_0000, 0);
    issue(0, 32'h8000_0010,      2'd2, 0, 32'd0,         1, 32'hDEAD55EF,  0);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_async_req_ready", 32'(req_ready), 32'd0);
    chk("rst_async_init_done", 32'(init_done), 32'd0);
    chk("rst_async_rsp_rdata", rsp_rdata, 32'd0);
    exp_q.delete();
    model_clear();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    wait_init();
    issue(0, 32'h8000_0010,      2'd2, 0, 32'd0,         1, 32'h0000_0000, 0);
    issue(0, 32'h8000_0013,      2'd0, 0, 32'd0,         1, 32'h0000_0000, 0);

    // Drain
    d = 0;
    while (exp_q.size() != 0 && d < 100) begin
      @(posedge clk);
      d++;
    end
    #1;
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
